// File: rtl/gate_unit_seq.sv
// Registered WIDTH-lane bitwise gate with a per-transaction op select and a built-in
// 4-point truth-table sweep that shares the same datapath and output register.
module gate_unit_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [2:0]       out_op,
    output logic             out_sweep,
    input  logic             sweep_start,
    input  logic [2:0]       sweep_op,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [3:0]       sweep_tt,
    output logic [1:0]       dbg_state
);
    // Handshake: a beat moves when valid && ready on the same rising edge; a producer
    // holds valid and its payload steady until that happens.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic [WIDTH-1:0] gate_f(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [2:0]       sw_op_q, sw_op_d;
    logic [3:0]       tt_q, tt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_y_q, out_y_d;
    logic [2:0]       out_op_q, out_op_d;
    logic             out_sweep_q, out_sweep_d;
    logic             done_q, done_d;
    logic             load_ok;
    logic [WIDTH-1:0] sweep_y;

    assign load_ok = !out_valid_q || out_ready;
    // Sweep stimulus: step[1] drives every lane of a, step[0] every lane of b.
    assign sweep_y = gate_f(sw_op_q, {WIDTH{step_q[1]}}, {WIDTH{step_q[0]}});

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        sw_op_d     = sw_op_q;
        tt_d        = tt_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_op_d    = out_op_q;
        out_sweep_d = out_sweep_q;
        done_d      = 1'b0;
        in_ready    = 1'b0;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (sweep_start) begin
                    state_d = SWEEP;
                    sw_op_d = sweep_op;
                    step_d  = 2'd0;
                    tt_d    = 4'd0;
                end else begin
                    in_ready = load_ok;
                    if (in_valid && load_ok) begin
                        out_valid_d = 1'b1;
                        out_y_d     = gate_f(in_op, in_a, in_b);
                        out_op_d    = in_op;
                        out_sweep_d = 1'b0;
                    end
                end
            end
            SWEEP: begin
                if (load_ok) begin
                    out_valid_d  = 1'b1;
                    out_y_d      = sweep_y;
                    out_op_d     = sw_op_q;
                    out_sweep_d  = 1'b1;
                    tt_d[step_q] = sweep_y[0];
                    step_d       = step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= 2'd0;
            sw_op_q     <= 3'd0;
            tt_q        <= 4'd0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_op_q    <= 3'd0;
            out_sweep_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            sw_op_q     <= sw_op_d;
            tt_q        <= tt_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_op_q    <= out_op_d;
            out_sweep_q <= out_sweep_d;
            done_q      <= done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_y      = out_y_q;
    assign out_op     = out_op_q;
    assign out_sweep  = out_sweep_q;
    assign sweep_busy = (state_q != IDLE);
    assign sweep_done = done_q;
    assign sweep_tt   = tt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_gate_unit_seq.sv
// Directed bench for gate_unit_seq: op table, backpressure, sweeps, arbitration, reset.
module tb_gate_unit_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic [2:0] out_op;
    logic       out_sweep;
    logic       sweep_start;
    logic [2:0] sweep_op;
    logic       sweep_busy;
    logic       sweep_done;
    logic [3:0] sweep_tt;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    gate_unit_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_op(out_op), .out_sweep(out_sweep),
        .sweep_start(sweep_start), .sweep_op(sweep_op),
        .sweep_busy(sweep_busy), .sweep_done(sweep_done),
        .sweep_tt(sweep_tt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        logic [7:0] op_exp[8];
        logic [7:0] nand_exp[4];
        logic [7:0] nor_exp[4];
        int n;
        int done_cnt;
        bit seen_done;
        bit got;

        op_exp   = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
        nand_exp = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
        nor_exp  = '{8'hFF, 8'h00, 8'h00, 8'h00};

        rst = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_op = 3'd0;
        out_ready = 1'b0; sweep_start = 1'b0; sweep_op = 3'd0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_op", out_op, 0);
        chk("rst_out_sweep", out_sweep, 0);
        chk("rst_busy", sweep_busy, 0);
        chk("rst_done", sweep_done, 0);
        chk("rst_tt", sweep_tt, 0);
        chk("rst_state", dbg_state, 0);

        // 1: all ops back to back
        tick();
        out_ready = 1'b1; in_valid = 1'b1; in_a = 8'hF0; in_b = 8'hCC;
        for (int op = 0; op < 8; op++) begin
            in_op = 3'(op);
            #1;
            chk("t1_in_ready", in_ready, 1);
            tick();
            chk("t1_valid", out_valid, 1);
            chk("t1_y", out_y, op_exp[op]);
            chk("t1_op", out_op, op);
            chk("t1_sweep", out_sweep, 0);
        end
        in_valid = 1'b0;
        tick();
        chk("t1_drained", out_valid, 0);

        // 2: backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55; in_op = 3'd4;
        #1;
        chk("t2_first_ready", in_ready, 1);
        tick();
        in_a = 8'h0F; in_b = 8'hFF; in_op = 3'd0;
        #1;
        chk("t2_blocked_ready", in_ready, 0);
        chk("t2_held_y", out_y, 8'hFF);
        tick();
        chk("t2_stable_y", out_y, 8'hFF);
        chk("t2_stable_op", out_op, 4);
        chk("t2_stable_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        chk("t2_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t2_second_valid", out_valid, 1);
        chk("t2_second_y", out_y, 8'h0F);
        chk("t2_second_op", out_op, 0);
        tick();
        chk("t2_drained", out_valid, 0);

        // 3: NAND sweep, full throughput
        sweep_start = 1'b1; sweep_op = 3'd2;
        #1;
        chk("t3_start_ready", in_ready, 0);
        tick();
        sweep_start = 1'b0;
        chk("t3_busy", sweep_busy, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_y", out_y, nand_exp[k]);
            chk("t3_sweep", out_sweep, 1);
            chk("t3_op", out_op, 2);
            chk("t3_busy_loop", sweep_busy, 1);
            chk("t3_no_early_done", sweep_done, 0);
        end
        tick();
        chk("t3_done", sweep_done, 1);
        chk("t3_busy_clear", sweep_busy, 0);
        chk("t3_tt", sweep_tt, 4'b0111);
        tick();
        chk("t3_done_pulse", sweep_done, 0);
        chk("t3_tt_hold", sweep_tt, 4'b0111);

        // 4: XOR sweep with out_ready toggling
        sweep_start = 1'b1; sweep_op = 3'd4;
        tick();
        sweep_start = 1'b0;
        exp_q = '{8'h00, 8'hFF, 8'hFF, 8'h00};
        n = 0; done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            out_ready = (c % 2 == 0);
            #1;
            if (out_valid && out_ready) begin
                n++;
                if (exp_q.size() > 0) chk("t4_y", out_y, exp_q.pop_front());
                chk("t4_sweep", out_sweep, 1);
            end
            if (sweep_done) done_cnt++;
            tick();
        end
        out_ready = 1'b1;
        chk("t4_result_count", n, 4);
        chk("t4_done_count", done_cnt, 1);
        chk("t4_tt", sweep_tt, 4'b0110);
        chk("t4_state", dbg_state, 0);

        // 5: sweep_start and in_valid together
        sweep_start = 1'b1; sweep_op = 3'd1;
        in_valid = 1'b1; in_a = 8'h3C; in_b = 8'h00; in_op = 3'd7;
        #1;
        chk("t5_ready_blocked", in_ready, 0);
        tick();
        sweep_start = 1'b0;
        seen_done = 1'b0; got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (sweep_done) seen_done = 1'b1;
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            if (out_valid) chk("t5_only_sweep_results", out_sweep, 1);
            tick();
        end
        chk("t5_accepted", got, 1);
        chk("t5_after_done", seen_done, 1);
        tick();
        in_valid = 1'b0;
        chk("t5_y", out_y, 8'h3C);
        chk("t5_op", out_op, 7);
        chk("t5_sweep", out_sweep, 0);
        chk("t5_tt", sweep_tt, 4'b1110);
        tick();

        // 6: reset in the middle of a sweep, then a fresh NOR sweep
        sweep_start = 1'b1; sweep_op = 3'd5;
        tick();
        sweep_start = 1'b0;
        tick(); tick();
        chk("t6_mid_state", dbg_state, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_y", out_y, 0);
        chk("t6_op", out_op, 0);
        chk("t6_sweep", out_sweep, 0);
        chk("t6_busy", sweep_busy, 0);
        chk("t6_done", sweep_done, 0);
        chk("t6_tt", sweep_tt, 0);
        chk("t6_state", dbg_state, 0);
        tick();
        sweep_start = 1'b1; sweep_op = 3'd3;
        tick();
        sweep_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t6_nor_y", out_y, nor_exp[k]);
            chk("t6_nor_op", out_op, 3);
        end
        tick();
        chk("t6_nor_done", sweep_done, 1);
        chk("t6_nor_tt", sweep_tt, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
